aes_loopback_bist: RTL

Synthesizable built-in self-test controller that drives an AES encrypt/decrypt top (kld, key_tx, key_rx, text_in) with a parametrised stream of LFSR-generated plaintexts. It checks each round-trip (dec_data == plaintext, enc_data != plaintext) and accumulates pass/fail statistics. It supports multi-vector runs, per-vector timeout, and a key-mismatch fault-injection mode that the single-shot bench flow lacks. It sits beside the AES top, and its status outputs feed a register block or top-level pins.

---
 rtl/aes_loopback_bist_if.sv | 23 ++
 rtl/aes_loopback_bist.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/aes_loopback_bist_if.sv
// AES top connection bundle: load strobe, keys and plaintext out; results and completion flags back.
interface aes_loopback_bist_if;
    logic         kld;
    logic [127:0] key_tx;
    logic [127:0] key_rx;
    logic [127:0] text_out;
    logic [127:0] enc_data;
    logic [127:0] dec_data;
    logic         enc_complete;
    logic         dec_complete;

    // BIST controller side
    modport master (
        output kld, key_tx, key_rx, text_out,
        input  enc_data, dec_data, enc_complete, dec_complete
    );

    // AES top side
    modport slave (
        input  kld, key_tx, key_rx, text_out,
        output enc_data, dec_data, enc_complete, dec_complete
    );
endinterface

// File: rtl/aes_loopback_bist.sv
// aes_loopback_bist: streams LFSR plaintexts through an AES encrypt/decrypt top,
// checks every round trip and keeps run statistics (count, errors, first failure).
module aes_loopback_bist #(
    parameter int NUM_VECTORS    = 16,
    parameter int KLD_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key_in,
    input  logic [127:0]       seed,
    input  logic               fault_inject,
    aes_loopback_bist_if.master aes,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout_flag,
    output logic [CNT_W-1:0]   vec_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   first_fail_idx
);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LOAD_W = (KLD_CYCLES > 1) ? $clog2(KLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ALL1  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_VECTORS);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(32'd0);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOAD_W-1:0] LOAD_ZERO = LOAD_W'(32'd0);
    localparam logic [LOAD_W-1:0] LOAD_ONE  = LOAD_W'(32'd1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(KLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Galois step with the GF(2^128) reduction polynomial x^128 + x^7 + x^2 + x + 1.
    function automatic logic [127:0] lfsr_step(input logic [127:0] v);
        lfsr_step = {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [127:0] seed_fix(input logic [127:0] s);
        seed_fix = (s == 128'h0) ? 128'h1 : s;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [LOAD_W-1:0]   load_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [127:0]        lfsr_r, key_tx_r, key_rx_r, enc_cap_r, dec_cap_r;
    logic                enc_seen_r, ord_err_r;
    logic                kld_r, busy_r, done_r, tf_r;
    logic [CNT_W-1:0]    vec_r, err_r, ffi_r;
    logic                fail_s;
    logic [CNT_W-1:0]    vec_inc_s, err_inc_s;

    assign aes.kld        = kld_r;
    assign aes.key_tx     = key_tx_r;
    assign aes.key_rx     = key_rx_r;
    assign aes.text_out   = lfsr_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = done_r & (err_r == CNT_ZERO) & ~tf_r;
    assign timeout_flag   = tf_r;
    assign vec_count      = vec_r;
    assign err_count      = err_r;
    assign first_fail_idx = ffi_r;

    // Per-vector verdict and the saturating/incrementing counter values.
    always_comb begin
        fail_s    = ord_err_r | (dec_cap_r != lfsr_r) | (enc_cap_r == lfsr_r);
        vec_inc_s = vec_r + CNT_ONE;
        err_inc_s = (err_r == CNT_ALL1) ? err_r : (err_r + CNT_ONE);
    end

    // Next-state decision for the run sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = state_r;
            end
            ST_LOAD: begin
                if (load_cnt_r == LOAD_LAST) state_nxt_s = ST_WAIT;
                else                         state_nxt_s = ST_LOAD;
            end
            ST_WAIT: begin
                if (aes.dec_complete)              state_nxt_s = ST_CHECK;
                else if (wait_cnt_r == WAIT_LAST)  state_nxt_s = ST_DONE;
                else                               state_nxt_s = ST_WAIT;
            end
            ST_CHECK: state_nxt_s = ST_NEXT;
            ST_NEXT: begin
                if (vec_inc_s == CNT_LAST) state_nxt_s = ST_DONE;
                else                       state_nxt_s = ST_LOAD;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Strobes registered from the next state so they change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kld_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            kld_r  <= (state_nxt_s == ST_LOAD);
            busy_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Run datapath: key/LFSR latching, result capture and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_r <= LOAD_ZERO;
            wait_cnt_r <= WAIT_ZERO;
            lfsr_r     <= 128'h0;
            key_tx_r   <= 128'h0;
            key_rx_r   <= 128'h0;
            enc_cap_r  <= 128'h0;
            dec_cap_r  <= 128'h0;
            enc_seen_r <= 1'b0;
            ord_err_r  <= 1'b0;
            tf_r       <= 1'b0;
            vec_r      <= CNT_ZERO;
            err_r      <= CNT_ZERO;
            ffi_r      <= CNT_ALL1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        key_tx_r   <= key_in;
                        key_rx_r   <= key_in ^ {127'd0, fault_inject};
                        lfsr_r     <= seed_fix(seed);
                        load_cnt_r <= LOAD_ZERO;
                        tf_r       <= 1'b0;
                        vec_r      <= CNT_ZERO;
                        err_r      <= CNT_ZERO;
                        ffi_r      <= CNT_ALL1;
                    end
                end
                ST_LOAD: begin
                    load_cnt_r <= load_cnt_r + LOAD_ONE;
                    wait_cnt_r <= WAIT_ZERO;
                    enc_seen_r <= 1'b0;
                    ord_err_r  <= 1'b0;
                end
                ST_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    // Keep the first ciphertext, but always take the one coinciding with dec_complete.
                    if (aes.enc_complete && (!enc_seen_r || aes.dec_complete)) enc_cap_r <= aes.enc_data;
                    if (aes.enc_complete) enc_seen_r <= 1'b1;
                    if (aes.dec_complete) begin
                        dec_cap_r <= aes.dec_data;
                        ord_err_r <= ~enc_seen_r & ~aes.enc_complete;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        tf_r  <= 1'b1;
                        err_r <= err_inc_s;
                        if (ffi_r == CNT_ALL1) ffi_r <= vec_r;
                    end
                end
                ST_CHECK: begin
                    if (fail_s) begin
                        err_r <= err_inc_s;
                        if (ffi_r == CNT_ALL1) ffi_r <= vec_r;
                    end
                end
                ST_NEXT: begin
                    vec_r      <= vec_inc_s;
                    lfsr_r     <= lfsr_step(lfsr_r);
                    load_cnt_r <= LOAD_ZERO;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
